// File: rtl/writeback_queue.sv
// Writeback queue: buffers register writes from the ALU and load paths and
// drains them in order, one per cycle, onto the register file write port.
// Also provides a pending-destination mask and a youngest-value forwarding lookup.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_value,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_value,
    output logic                     in_ready,
    output logic                     wb_en,
    output logic [ADDR_W-1:0]        wb_dest,
    output logic [DATA_W-1:0]        wb_value,
    output logic [(1<<ADDR_W)-1:0]   busy_mask,
    input  logic [ADDR_W-1:0]        fwd_src,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_value
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, alu_slot;
    logic [CW-1:0]     count_q, count_d, occ_after_pop;
    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_dest_q;
    logic [DATA_W-1:0] wb_value_q;
    logic              pop, mem_acc, alu_acc;

    // Pop/ready/accept decisions and next pointer/count values.
    // Ready only looks at registered occupancy so producers never see a loop
    // through their own valid signals; room for two writes is guaranteed.
    always_comb begin
        pop           = (count_q != '0);
        occ_after_pop = count_q - CW'(pop);
        in_ready      = (occ_after_pop <= CW'(DEPTH - 2));
        mem_acc       = mem_valid && in_ready && (mem_dest != '0);
        alu_acc       = alu_valid && in_ready && (alu_dest != '0);
        alu_slot      = tail_q + PW'(mem_acc);
        head_d        = head_q + PW'(pop);
        tail_d        = tail_q + PW'(mem_acc) + PW'(alu_acc);
        count_d       = count_q - CW'(pop) + CW'(mem_acc) + CW'(alu_acc);
    end

    // Entry storage; the load entry is older, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            dest_q[tail_q]  <= mem_dest;
            value_q[tail_q] <= mem_value;
        end
        if (alu_acc) begin
            dest_q[alu_slot]  <= alu_dest;
            value_q[alu_slot] <= alu_value;
        end
    end

    // Pointers, occupancy and the registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wb_en_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_value_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wb_en_q <= pop;
            if (pop) begin
                wb_dest_q  <= dest_q[head_q];
                wb_value_q <= value_q[head_q];
            end
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_value = wb_value_q;

    // Busy mask and forwarding: the wb register is lowest priority, then queue
    // entries oldest to youngest so the youngest match overrides the rest.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        busy_mask = '0;
        fwd_hit   = 1'b0;
        fwd_value = '0;
        if (wb_en_q) begin
            busy_mask[wb_dest_q] = 1'b1;
            if (wb_dest_q == fwd_src) begin
                fwd_hit   = 1'b1;
                fwd_value = wb_value_q;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                busy_mask[dest_q[idx]] = 1'b1;
                if (dest_q[idx] == fwd_src) begin
                    fwd_hit   = 1'b1;
                    fwd_value = value_q[idx];
                end
            end
        end
        busy_mask[0] = 1'b0;
        if (fwd_src == '0) begin
            fwd_hit   = 1'b0;
            fwd_value = '0;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with hand-computed expectations and a
// small occupancy model for the saturation/wrap run.
module tb_writeback_queue;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [3:0]  alu_dest, mem_dest, fwd_src;
    logic [31:0] alu_value, mem_value;
    logic        in_ready, wb_en, fwd_hit;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value, fwd_value;
    logic [15:0] busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_dest  (alu_dest),
        .alu_value (alu_value),
        .mem_valid (mem_valid),
        .mem_dest  (mem_dest),
        .mem_value (mem_value),
        .in_ready  (in_ready),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .wb_value  (wb_value),
        .busy_mask (busy_mask),
        .fwd_src   (fwd_src),
        .fwd_hit   (fwd_hit),
        .fwd_value (fwd_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_dest = '0; alu_value = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_value = '0;
    endtask

    // saturation model state
    int          m_cnt;
    bit          m_pop, m_rdy, saw_low, on;
    logic [35:0] m_q[$];
    logic [35:0] exp_e;
    int          seq, n_acc, n_wr;

    initial begin
        idle_inputs();
        fwd_src = '0;
        reset   = 1'b1;
        #12 reset = 1'b0;

        // reset values
        check("rst_wb_en",    wb_en,     1'b0);
        check("rst_wb_dest",  wb_dest,   4'd0);
        check("rst_wb_value", wb_value,  32'd0);
        check("rst_busy",     busy_mask, 16'd0);
        check("rst_fwd_hit",  fwd_hit,   1'b0);
        check("rst_in_ready", in_ready,  1'b1);

        // single ALU write: dest 3, 0x11
        alu_valid = 1'b1; alu_dest = 4'd3; alu_value = 32'h11;
        tick();
        idle_inputs();
        fwd_src = 4'd3;
        #0;
        check("t1_e1_wb_en",  wb_en,        1'b0);
        check("t1_e1_busy3",  busy_mask,    16'h0008);
        check("t1_e1_fhit",   fwd_hit,      1'b1);
        check("t1_e1_fval",   fwd_value,    32'h11);
        tick();
        check("t1_e2_wb_en",  wb_en,        1'b1);
        check("t1_e2_dest",   wb_dest,      4'd3);
        check("t1_e2_value",  wb_value,     32'h11);
        check("t1_e2_busy3",  busy_mask,    16'h0008);
        tick();
        check("t1_e3_wb_en",  wb_en,        1'b0);
        check("t1_e3_busy",   busy_mask,    16'h0000);
        check("t1_e3_fhit",   fwd_hit,      1'b0);

        // same destination from both producers
        mem_valid = 1'b1; mem_dest = 4'd5; mem_value = 32'hAA;
        alu_valid = 1'b1; alu_dest = 4'd5; alu_value = 32'hBB;
        fwd_src   = 4'd5;
        tick();
        idle_inputs();
        #0;
        check("t2_e1_wb_en",  wb_en,     1'b0);
        check("t2_e1_fhit",   fwd_hit,   1'b1);
        check("t2_e1_fval",   fwd_value, 32'hBB);
        tick();
        check("t2_e2_wb_en",  wb_en,     1'b1);
        check("t2_e2_value",  wb_value,  32'hAA);
        check("t2_e2_fval",   fwd_value, 32'hBB);
        tick();
        check("t2_e3_wb_en",  wb_en,     1'b1);
        check("t2_e3_value",  wb_value,  32'hBB);
        check("t2_e3_fval",   fwd_value, 32'hBB);
        tick();
        check("t2_e4_wb_en",  wb_en,     1'b0);
        check("t2_e4_fhit",   fwd_hit,   1'b0);
        check("t2_e4_fval",   fwd_value, 32'h0);

        // dest 0 is discarded
        alu_valid = 1'b1; alu_dest = 4'd0; alu_value = 32'hFF;
        fwd_src   = 4'd0;
        tick();
        idle_inputs();
        #0;
        check("t4_e1_wb_en",  wb_en,     1'b0);
        check("t4_e1_busy",   busy_mask, 16'h0000);
        check("t4_e1_ready",  in_ready,  1'b1);
        check("t4_e1_fhit",   fwd_hit,   1'b0);
        tick();
        check("t4_e2_wb_en",  wb_en,     1'b0);

        // mem dest 0 alongside a real alu write: alu must land in the first slot
        mem_valid = 1'b1; mem_dest = 4'd0; mem_value = 32'hDEAD;
        alu_valid = 1'b1; alu_dest = 4'd6; alu_value = 32'h66;
        fwd_src   = 4'd6;
        tick();
        idle_inputs();
        #0;
        check("t4b_e1_busy",  busy_mask, 16'h0040);
        check("t4b_e1_fval",  fwd_value, 32'h66);
        tick();
        check("t4b_e2_wb_en", wb_en,     1'b1);
        check("t4b_e2_dest",  wb_dest,   4'd6);
        check("t4b_e2_value", wb_value,  32'h66);
        tick();
        check("t4b_e3_wb_en", wb_en,     1'b0);

        // saturation with both producers every cycle, across pointer wrap
        m_cnt = 0; saw_low = 0; seq = 0; n_acc = 0; n_wr = 0;
        fwd_src = '0;
        for (int c = 0; c < 20; c++) begin
            on    = (c < 12);
            m_pop = (m_cnt > 0);
            m_rdy = ((m_cnt - int'(m_pop)) <= 2);
            check("sat_ready", in_ready, m_rdy);
            if (!m_rdy) saw_low = 1;
            mem_valid = on; mem_dest = 4'(1 + (seq % 7)); mem_value = 32'h1000_0000 + 32'(seq);
            alu_valid = on; alu_dest = 4'(8 + (seq % 8)); alu_value = 32'h2000_0000 + 32'(seq);
            tick();
            check("sat_wb_en", wb_en, m_pop);
            if (m_pop) begin
                exp_e = m_q.pop_front();
                n_wr++;
                check("sat_wb_dest",  wb_dest,  exp_e[35:32]);
                check("sat_wb_value", wb_value, exp_e[31:0]);
            end
            if (on && m_rdy) begin
                m_q.push_back({mem_dest, mem_value});
                m_q.push_back({alu_dest, alu_value});
                n_acc += 2;
                seq++;
            end
            m_cnt = m_cnt - int'(m_pop) + ((on && m_rdy) ? 2 : 0);
        end
        idle_inputs();
        check("sat_saw_not_ready", saw_low, 1'b1);
        check("sat_all_drained",   m_q.size(), 0);
        check("sat_wr_eq_acc",     n_wr, n_acc);
        check("sat_end_wb_en",     wb_en, 1'b0);

        // fill three entries, then reset between edges
        mem_valid = 1'b1; mem_dest = 4'd1; mem_value = 32'hA1;
        alu_valid = 1'b1; alu_dest = 4'd2; alu_value = 32'hA2;
        tick();
        mem_dest = 4'd3; mem_value = 32'hA3;
        alu_dest = 4'd4; alu_value = 32'hA4;
        tick();
        idle_inputs();
        fwd_src = 4'd4;
        #0;
        check("t5_pre_wb_en", wb_en,     1'b1);
        check("t5_pre_busy",  busy_mask, 16'h001E);
        check("t5_pre_fval",  fwd_value, 32'hA4);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_wb_en", wb_en,     1'b0);
        check("t5_rst_busy",  busy_mask, 16'h0000);
        check("t5_rst_fhit",  fwd_hit,   1'b0);
        check("t5_rst_dest",  wb_dest,   4'd0);
        check("t5_rst_ready", in_ready,  1'b1);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_post_wb_en", wb_en,     1'b0);
            check("t5_post_busy",  busy_mask, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Writeback queue between the execute/memory stages and the register file write port. Buffers up to DEPTH pending register writes from two producers: the ALU path and the variable-latency load path. It drains them in order, one per cycle, onto the register file's single write port. It also exposes a pending-destination mask for the hazard unit and a forwarding lookup for decode.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- DATA_W, 32: write value width; matches MAX_LENGTH.
- ADDR_W, 4: register index width; matches REG_LENGTH.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- alu_valid  in  1  ALU result offered this cycle.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_value  in  DATA_W  ALU result.
- mem_valid  in  1  load result offered this cycle.
- mem_dest  in  ADDR_W  load destination register.
- mem_value  in  DATA_W  loaded data.
- in_ready  out  1  both producers may enqueue this cycle; combinational from occupancy.
- wb_en  out  1  register file write_enabled; registered.
- wb_dest  out  ADDR_W  register file destination_source; registered.
- wb_value  out  DATA_W  register file writing_value; registered.
- busy_mask  out  2^ADDR_W  bit r set if any queued entry or the current wb output targets register r.
- fwd_src  in  ADDR_W  register decode wants to read.
- fwd_hit  out  1  a pending write to fwd_src exists.
- fwd_value  out  DATA_W  youngest pending value for fwd_src; 0 when fwd_hit is 0.

## Operation
- Storage: circular buffer of DEPTH {dest, value} entries, with head and tail pointers wrapping modulo DEPTH and an occupancy count in 0..DEPTH.
- Pop rule: pop is 1 when count > 0.
  - On every posedge with pop = 1: wb_en←1 and wb_dest/wb_value←head entry; head advances.
  - With count = 0: wb_en←0; wb_dest and wb_value hold their previous values.
- Ready rule: in_ready = (count − pop) ≤ DEPTH−2. This guarantees room for two enqueues in the same cycle as a pop.
- Enqueue rule:
  - A producer's entry is written when its valid and in_ready are both 1.
  - Valid while in_ready = 0 is ignored. The producer must hold its data and retry.
  - When both producers enqueue in the same cycle, the mem entry is written first (older instruction), then the alu entry. Tail advances by 2.
  - An entry with dest = 0 is discarded at enqueue: no slot is used and tail does not advance. Register 0 is hardwired to zero downstream.
- Count update: count_next = count − pop + accepted entries. Count never exceeds DEPTH and never goes below 0.
- Same destination from both producers in one cycle: both entries are queued. The alu entry drains later, so it wins in the register file.
- busy_mask: OR over all valid queue entries and the wb output register (when wb_en = 1) of onehot(dest). Bit 0 is always 0.
- Forwarding priority, highest first:
  1. Youngest matching queue entry, searched from tail−1 back to head.
  2. The wb output register, if wb_en = 1 and wb_dest = fwd_src.
  3. No match: fwd_hit = 0.
  - fwd_src = 0 always gives fwd_hit = 0.

## Timing
- Reset values: count = 0, head = 0, tail = 0, wb_en = 0, wb_dest = 0, wb_value = 0, busy_mask = 0, fwd_hit = 0, in_ready = 1.
- Reset asserted mid-operation discards all queued entries asynchronously. wb_en drops immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N into an empty queue appears on wb_* after edge N+1. Minimum enqueue-to-write-enable latency is 2 edges.
- The register file commits on the following negedge, so the value is readable from the register file in the second half of that cycle.
- Sustained throughput: 1 write per cycle. With both producers active every cycle, in_ready falls once count reaches DEPTH−1 after pop.
- in_ready, busy_mask, fwd_hit and fwd_value are combinational from registered state and fwd_src. None of them depends on the current cycle's valid inputs.

## Test plan
- Reset, then alu_valid = 1, alu_dest = 3, alu_value = 0x11 for one cycle → wb_en = 1, wb_dest = 3, wb_value = 0x11 two edges later, for exactly one cycle; busy_mask[3] is set in the two intervening cycles.
- Same cycle: mem (dest 5, 0xAA) and alu (dest 5, 0xBB) → wb sequence 0xAA then 0xBB on consecutive cycles; fwd_src = 5 returns 0xBB while both are pending.
- Both producers valid every cycle with distinct dests, DEPTH = 4 → in_ready deasserts once the queue is saturated; no entry is lost or duplicated; output order matches acceptance order, including across pointer wrap.
- alu_dest = 0 with value 0xFF → no wb_en pulse, count unchanged, busy_mask[0] = 0, fwd_src = 0 gives fwd_hit = 0.
- Fill the queue with 3 entries, then assert reset between clock edges → wb_en, busy_mask and count are 0 immediately; after release, no stale writes appear.
